// File: rtl/dec_queue_pkg.sv
// Shared decode types for the decode stage: dec_entry layout, misconduct codes,
// queue state and the per-lane instruction decoder (package p_hardisc).
package p_hardisc;

  typedef logic [3:0] f_part;   // {funct7[5], funct3}
  typedef logic [4:0] rf_add;
  typedef logic [2:0] sctrl;    // operand sources: {imm, rs2, rs1}
  typedef logic [7:0] ictrl;    // unit / side-effect flags
  typedef logic [2:0] imiscon;

  localparam imiscon IMISCON_FREE = 3'd0;  // no misconduct
  localparam imiscon IMISCON_FERR = 3'd1;  // fetch error
  localparam imiscon IMISCON_MISA = 3'd2;  // alignment error
  localparam imiscon IMISCON_ILLE = 3'd3;  // illegal encoding
  localparam imiscon IMISCON_DSCR = 3'd4;  // prediction on a non-control-flow instr

  localparam int SC_RS1 = 0, SC_RS2 = 1, SC_IMM = 2;
  localparam int IC_ALU = 0, IC_LOAD = 1, IC_STORE = 2, IC_BRANCH = 3,
                 IC_JUMP = 4, IC_SYS = 5, IC_RDW = 6, IC_PC = 7;

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f,
                         OPC_JALR = 7'h67, OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03,
                         OPC_STORE = 7'h23, OPC_OPIMM = 7'h13, OPC_OP = 7'h33,
                         OPC_FENCE = 7'h0f, OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic [20:0] payload;   // immediate, sign-extended to 21 bits (U-type: imm[31:12])
    f_part       f;
    rf_add       rs1;
    rf_add       rs2;
    rf_add       rd;
    sctrl        sc;
    ictrl        ic;
    imiscon      mis;
  } dec_entry;

  typedef enum logic {DQ_RUN, DQ_HALT} dq_state;

  // RV32I decoder. A misconducting instruction carries no register operands so
  // nothing downstream can touch the register file on its behalf.
  function automatic dec_entry decode(input logic [31:0] ins, input logic [2:0] ferr,
                                      input logic aerr, input logic pred);
    dec_entry e;
    logic     ill, cfi;
    logic [20:0] imm_i;
    e     = '0;
    ill   = 1'b0;
    cfi   = 1'b0;
    imm_i = {{9{ins[31]}}, ins[31:20]};
    e.f   = {ins[30], ins[14:12]};
    case (ins[6:0])
      OPC_LUI:    begin e.payload = {1'b0, ins[31:12]}; e.sc[SC_IMM] = 1'b1;
                        e.ic[IC_ALU] = 1'b1; e.ic[IC_RDW] = 1'b1; end
      OPC_AUIPC:  begin e.payload = {1'b0, ins[31:12]}; e.sc[SC_IMM] = 1'b1;
                        e.ic[IC_ALU] = 1'b1; e.ic[IC_RDW] = 1'b1; e.ic[IC_PC] = 1'b1; end
      OPC_JAL:    begin e.payload = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                        e.ic[IC_JUMP] = 1'b1; e.ic[IC_RDW] = 1'b1; e.ic[IC_PC] = 1'b1; cfi = 1'b1; end
      OPC_JALR:   begin e.payload = imm_i; e.sc[SC_RS1] = 1'b1;
                        e.ic[IC_JUMP] = 1'b1; e.ic[IC_RDW] = 1'b1; cfi = 1'b1; end
      OPC_BRANCH: begin e.payload = {{8{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                        e.sc[SC_RS1] = 1'b1; e.sc[SC_RS2] = 1'b1;
                        e.ic[IC_BRANCH] = 1'b1; e.ic[IC_PC] = 1'b1; cfi = 1'b1; end
      OPC_LOAD:   begin e.payload = imm_i; e.sc[SC_RS1] = 1'b1;
                        e.ic[IC_LOAD] = 1'b1; e.ic[IC_RDW] = 1'b1; end
      OPC_STORE:  begin e.payload = {{9{ins[31]}}, ins[31:25], ins[11:7]};
                        e.sc[SC_RS1] = 1'b1; e.sc[SC_RS2] = 1'b1; e.ic[IC_STORE] = 1'b1; end
      OPC_OPIMM:  begin e.payload = imm_i; e.sc[SC_RS1] = 1'b1; e.sc[SC_IMM] = 1'b1;
                        e.ic[IC_ALU] = 1'b1; e.ic[IC_RDW] = 1'b1; end
      OPC_OP:     begin e.sc[SC_RS1] = 1'b1; e.sc[SC_RS2] = 1'b1;
                        e.ic[IC_ALU] = 1'b1; e.ic[IC_RDW] = 1'b1;
                        ill = (ins[31:25] != 7'h00) && (ins[31:25] != 7'h20); end
      OPC_FENCE:  begin e.payload = imm_i; e.ic[IC_SYS] = 1'b1; end
      OPC_SYSTEM: begin e.payload = imm_i; e.sc[SC_RS1] = 1'b1; e.ic[IC_SYS] = 1'b1; end
      default:    ill = 1'b1;
    endcase
    e.rs1 = e.sc[SC_RS1] ? ins[19:15] : '0;
    e.rs2 = e.sc[SC_RS2] ? ins[24:20] : '0;
    e.rd  = e.ic[IC_RDW] ? ins[11:7]  : '0;
    // Earliest pipeline fault wins.
    if (ferr != 3'd0)      e.mis = IMISCON_FERR;
    else if (aerr)         e.mis = IMISCON_MISA;
    else if (ill)          e.mis = IMISCON_ILLE;
    else if (pred && !cfi) e.mis = IMISCON_DSCR;
    if (e.mis != IMISCON_FREE) begin
      e.rs1 = '0;
      e.rs2 = '0;
      e.rd  = '0;
      e.ic  = '0;
    end
    return e;
  endfunction

endpackage

// File: rtl/dec_queue_fifo.sv
// dec_fifo: circular buffer of dec_entry with LANES write ports (first wr_num_i
// slots of wr_data_i are written in order) and one read port, plus flush.
module dec_fifo import p_hardisc::*; #(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [$clog2(LANES+1)-1:0]   wr_num_i,
  input  dec_entry [LANES-1:0]         wr_data_i,
  input  logic                         rd_i,
  output dec_entry                     head_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(LANES + 1);

  dec_entry        mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            rd_en;

  assign rd_en   = rd_i && (count_q != '0);
  assign count_d = count_q + CW'(wr_num_i) - CW'(rd_en);

  // Storage: write the accepted slots at consecutive addresses from wptr.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i)
      for (int k = 0; k < LANES; k++)
        if (NW'(k) < wr_num_i) mem_q[wptr_q + AW'(k)] <= wr_data_i[k];
  end

  // Pointers and occupancy; flush and reset both empty the buffer.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(wr_num_i);
      rptr_q  <= rptr_q + AW'(rd_en);
      count_q <= count_d;
    end
  end

  assign head_o  = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/dec_queue.sv
// dec_queue: parallel decode of up to LANES aligned instructions into an
// in-order decoded-instruction FIFO; halts input after a misconducting entry.
// Optional macro DEC_QUEUE_BYPASS_EN: zero-latency path from lane 0 to the head
// when the queue is empty.
module dec_queue import p_hardisc::*; #(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                         s_clk_i,
  input  logic                         s_reset_i,
  input  logic                         s_flush_i,
  input  logic [LANES-1:0]             s_in_valid_i,
  input  logic [LANES-1:0][31:0]       s_instr_i,
  input  logic [LANES-1:0][2:0]        s_fetch_error_i,
  input  logic [LANES-1:0]             s_align_error_i,
  input  logic [LANES-1:0]             s_prediction_i,
  output logic                         s_ready_o,
  output logic [$clog2(LANES+1)-1:0]   s_accepted_o,
  output logic                         s_valid_o,
  input  logic                         s_pop_i,
  output logic [20:0]                  s_payload_o,
  output f_part                        s_f_o,
  output rf_add                        s_rs1_o,
  output rf_add                        s_rs2_o,
  output rf_add                        s_rd_o,
  output sctrl                         s_sctrl_o,
  output ictrl                         s_ictrl_o,
  output imiscon                       s_imiscon_o,
  output logic                         s_halted_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(LANES + 1);

  dq_state              state_q, state_d;
  dec_entry [LANES-1:0] dec, wr_data;
  dec_entry             fifo_head, head;
  logic [LANES-1:0]     take;
  logic [NW-1:0]        n_take, acc, wr_num;
  logic [CW-1:0]        count;
  logic                 push_ok, mis_acc, byp, byp_pop;

  for (genvar l = 0; l < LANES; l++) begin : g_dec
    assign dec[l] = decode(s_instr_i[l], s_fetch_error_i[l], s_align_error_i[l], s_prediction_i[l]);
  end

  // Contiguous valid prefix, cut after the first misconducting lane.
  always_comb begin
    logic chain;
    chain   = 1'b1;
    take    = '0;
    n_take  = '0;
    mis_acc = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      take[l] = chain && s_in_valid_i[l];
      chain   = take[l] && (dec[l].mis == IMISCON_FREE);
      n_take  = n_take + NW'(take[l]);
      mis_acc = mis_acc || (take[l] && (dec[l].mis != IMISCON_FREE));
    end
  end

  assign s_ready_o    = (state_q == DQ_RUN) && (count <= CW'(DEPTH - LANES));
  assign push_ok      = s_ready_o && !s_flush_i && !s_reset_i;
  assign acc          = push_ok ? n_take : '0;
  assign s_accepted_o = acc;

`ifdef DEC_QUEUE_BYPASS_EN
  // Lane 0 goes straight to issue when nothing is queued ahead of it; if it is
  // popped at once it never enters storage.
  assign byp     = (count == '0) && push_ok && take[0];
  assign byp_pop = byp && s_pop_i;
`else
  assign byp     = 1'b0;
  assign byp_pop = 1'b0;
`endif

  assign wr_num = acc - NW'(byp_pop);

  for (genvar k = 0; k < LANES; k++) begin : g_wr
    if (k + 1 < LANES) begin : g_sh
      assign wr_data[k] = byp_pop ? dec[k+1] : dec[k];
    end else begin : g_last
      assign wr_data[k] = dec[k];
    end
  end

  dec_fifo #(.LANES(LANES), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (s_clk_i),
    .reset_i   (s_reset_i),
    .flush_i   (s_flush_i),
    .wr_num_i  (wr_num),
    .wr_data_i (wr_data),
    .rd_i      (s_pop_i),
    .head_o    (fifo_head),
    .count_o   (count)
  );

  // State register: flush or reset always return to RUN.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i || s_flush_i) state_q <= DQ_RUN;
    else                        state_q <= state_d;
  end

  // Next state: enter HALT once a misconducting lane is written.
  always_comb begin
    state_d = state_q;
    if (state_q == DQ_RUN && push_ok && mis_acc) state_d = DQ_HALT;
  end

  assign s_halted_o  = (state_q == DQ_HALT);
  assign s_valid_o   = (count != '0) || byp;
  assign head        = byp ? dec[0] : fifo_head;
  assign s_payload_o = head.payload;
  assign s_f_o       = head.f;
  assign s_rs1_o     = head.rs1;
  assign s_rs2_o     = head.rs2;
  assign s_rd_o      = head.rd;
  assign s_sctrl_o   = head.sc;
  assign s_ictrl_o   = head.ic;
  assign s_imiscon_o = head.mis;

endmodule
